// File: rtl/router_egress_arbiter_pkg.sv
// Shared definitions for the router egress arbiter: FSM encodings and packet framing constants.
// Framing: src_id, dest_id, size, <size data bytes>, crc.
package router_egress_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_XFER  = 2'd2
    } state_t;

    localparam int HDR_BYTES = 3;
    localparam int CRC_BYTES = 1;
    localparam int SIZE_IDX  = 2;

endpackage

// File: rtl/router_egress_arbiter_rr_picker.sv
// Combinational round-robin picker: one-hot pick of the first requester after the one-hot 'last'.
// Shared with the ingress side, so it carries no state and no clock.
module router_rr_picker #(
    parameter int NPORT = 3
) (
    input  logic [NPORT-1:0] req,
    input  logic [NPORT-1:0] last,
    output logic [NPORT-1:0] pick
);

    logic [NPORT-1:0] above_mask;
    logic [NPORT-1:0] req_hi;
    logic [NPORT-1:0] pool;

    // Bits strictly above 'last'; when last is the top port this wraps to empty.
    assign above_mask = ~((last << 1) - NPORT'(1));
    assign req_hi     = req & above_mask;
    assign pool       = (|req_hi) ? req_hi : req;
    // Isolate the lowest set bit of the candidate pool.
    assign pick       = pool & (~pool + NPORT'(1));

endmodule

// File: rtl/router_egress_arbiter.sv
// Round-robin egress arbiter: streams whole packets from NPORT FWFT FIFOs onto one valid/ready byte link.
// Optional parity check of the crc byte is enabled by defining ROUTER_ARB_CRC_CHECK_EN.
module router_egress_arbiter
    import router_egress_arbiter_pkg::*;
#(
    parameter int UWIDTH = 8,
    parameter int NPORT  = 3,
    parameter int WIDTH  = 11
) (
    input  logic                    clk2,
    input  logic                    rst,
    input  logic [NPORT-1:0]        fifo_empty,
    input  logic [NPORT*UWIDTH-1:0] fifo_data,
    output logic [NPORT-1:0]        fifo_rd,
    input  logic                    link_ready,
    output logic                    link_valid,
    output logic [UWIDTH-1:0]       link_data,
    output logic [NPORT-1:0]        grant,
    output logic                    pkt_done,
    output logic                    crc_err
);

    localparam int CW      = $clog2(WIDTH + 1);
    localparam int MAX_LEN = WIDTH - HDR_BYTES - CRC_BYTES;

    state_t             state_reg, state_next;
    logic [NPORT-1:0]   grant_reg, grant_next;
    logic [NPORT-1:0]   rr_last_reg, rr_last_next;
    logic               link_valid_reg, link_valid_next;
    logic [UWIDTH-1:0]  link_data_reg, link_data_next;
    logic [CW-1:0]      byte_cnt_reg, byte_cnt_next;
    logic [CW-1:0]      len_reg, len_next;
    logic               pkt_done_reg, pkt_done_next;

    logic [NPORT-1:0]   pick;
    logic [UWIDTH-1:0]  head;
    logic               has_data;
    logic               req_any;
    logic [CW-1:0]      pkt_total;
    logic               past_hdr;
    logic               all_popped;
    logic               handshake;
    logic               pop;
    logic               done;

    router_rr_picker #(
        .NPORT (NPORT)
    ) u_picker (
        .req  (~fifo_empty),
        .last (rr_last_reg),
        .pick (pick)
    );

    // Head byte of the granted FIFO, built as an OR chain of one-hot masked lanes.
    logic [UWIDTH-1:0] head_acc [NPORT+1];
    assign head_acc[0] = '0;
    generate
        for (genvar gi = 0; gi < NPORT; gi++) begin : g_head
            assign head_acc[gi+1] = head_acc[gi] |
                (grant_reg[gi] ? fifo_data[gi*UWIDTH +: UWIDTH] : '0);
        end
    endgenerate
    assign head = head_acc[NPORT];

    assign req_any    = |(~fifo_empty);
    assign has_data   = |(grant_reg & ~fifo_empty);
    assign pkt_total  = len_reg + CW'(HDR_BYTES + CRC_BYTES);
    // len_reg is only meaningful once the size byte has been popped.
    assign past_hdr   = byte_cnt_reg > CW'(SIZE_IDX);
    assign all_popped = past_hdr && (byte_cnt_reg == pkt_total);
    assign handshake  = link_valid_reg && link_ready;
    assign pop        = (state_reg == ST_XFER) && has_data && !all_popped &&
                        (!link_valid_reg || link_ready);
    assign done       = (state_reg == ST_XFER) && all_popped && handshake;

    assign fifo_rd    = pop ? grant_reg : '0;
    assign grant      = grant_reg;
    assign link_valid = link_valid_reg;
    assign link_data  = link_data_reg;
    assign pkt_done   = pkt_done_reg;

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        rr_last_next    = rr_last_reg;
        link_valid_next = link_valid_reg;
        link_data_next  = link_data_reg;
        byte_cnt_next   = byte_cnt_reg;
        len_next        = len_reg;
        pkt_done_next   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (req_any) begin
                    grant_next = pick;
                    state_next = ST_GRANT;
                end
            end
            ST_GRANT: begin
                byte_cnt_next = '0;
                state_next    = ST_XFER;
            end
            ST_XFER: begin
                if (pop) begin
                    link_data_next  = head;
                    link_valid_next = 1'b1;
                    byte_cnt_next   = byte_cnt_reg + CW'(1);
                    if (byte_cnt_reg == CW'(SIZE_IDX)) begin
                        len_next = (head > UWIDTH'(MAX_LEN)) ? CW'(MAX_LEN) : CW'(head);
                    end
                end else if (handshake) begin
                    link_valid_next = 1'b0;
                end
                if (done) begin
                    pkt_done_next = 1'b1;
                    rr_last_next  = grant_reg;
                    grant_next    = '0;
                    state_next    = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk2 or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            grant_reg      <= '0;
            rr_last_reg    <= {1'b1, {(NPORT-1){1'b0}}};
            link_valid_reg <= 1'b0;
            link_data_reg  <= '0;
            byte_cnt_reg   <= '0;
            len_reg        <= '0;
            pkt_done_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            rr_last_reg    <= rr_last_next;
            link_valid_reg <= link_valid_next;
            link_data_reg  <= link_data_next;
            byte_cnt_reg   <= byte_cnt_next;
            len_reg        <= len_next;
            pkt_done_reg   <= pkt_done_next;
        end
    end

`ifdef ROUTER_ARB_CRC_CHECK_EN
    logic parity_reg, parity_next;
    logic crc_bad_reg, crc_bad_next;
    logic crc_err_reg, crc_err_next;
    logic crc_pop;

    assign crc_pop = pop && past_hdr && (byte_cnt_reg == pkt_total - CW'(1));

    // Parity covers every byte ahead of the crc; the verdict is held until the crc is accepted.
    always_comb begin
        parity_next  = parity_reg;
        crc_bad_next = crc_bad_reg;
        crc_err_next = done && crc_bad_reg;
        if (state_reg == ST_GRANT) begin
            parity_next  = 1'b0;
            crc_bad_next = 1'b0;
        end else if (crc_pop) begin
            crc_bad_next = (head != {{(UWIDTH-1){1'b0}}, parity_reg});
        end else if (pop) begin
            parity_next = parity_reg ^ (^head);
        end
    end

    always_ff @(posedge clk2 or negedge rst) begin
        if (!rst) begin
            parity_reg  <= 1'b0;
            crc_bad_reg <= 1'b0;
            crc_err_reg <= 1'b0;
        end else begin
            parity_reg  <= parity_next;
            crc_bad_reg <= crc_bad_next;
            crc_err_reg <= crc_err_next;
        end
    end

    assign crc_err = crc_err_reg;
`else
    assign crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_egress_arbiter.sv
// Self-checking bench for router_egress_arbiter: FWFT FIFO model, packet table, round-robin,
// back-pressure and mid-packet reset sequences. Honours ROUTER_ARB_CRC_CHECK_EN for crc_err expectations.
module tb_router_egress_arbiter;

    localparam int UW = 8;
    localparam int NP = 3;
    localparam int WD = 11;
`ifdef ROUTER_ARB_CRC_CHECK_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    logic              clk2 = 1'b0;
    logic              rst  = 1'b0;
    logic [NP-1:0]     fifo_empty;
    logic [NP*UW-1:0]  fifo_data;
    logic [NP-1:0]     fifo_rd;
    logic              link_ready;
    logic              link_valid;
    logic [UW-1:0]     link_data;
    logic [NP-1:0]     grant;
    logic              pkt_done;
    logic              crc_err;

    router_egress_arbiter #(.UWIDTH(UW), .NPORT(NP), .WIDTH(WD)) dut (
        .clk2       (clk2),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd    (fifo_rd),
        .link_ready (link_ready),
        .link_valid (link_valid),
        .link_data  (link_data),
        .grant      (grant),
        .pkt_done   (pkt_done),
        .crc_err    (crc_err)
    );

    always #5 clk2 = ~clk2;

    typedef struct {
        int         port;
        int         n;
        logic [7:0] b [13];
        int         exp_grant;
        int         exp_fwd;
        int         exp_left;
        bit         crc_bad;
    } vec_t;

    vec_t        vecs [6];
    int          rr_exp [6] = '{1, 2, 4, 1, 2, 4};
    logic [7:0]  stall_pkt [7] = '{8'd0, 8'd1, 8'd3, 8'd10, 8'd11, 8'd12, 8'd1};

    logic [7:0]  q [NP][$];
    logic [7:0]  rx [$];
    int          rx_cyc [$];
    int          grant_log [$];
    int          cyc, tests, fails, viol, done_cnt, last_done_cyc, grant_cyc, pops_total;
    bit          last_crc_err, prev_stall;
    logic [NP-1:0] last_grant;
    logic [7:0]  prev_data;

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int log_at(input int i);
        return (i < grant_log.size()) ? grant_log[i] : -1;
    endfunction

    task automatic refresh();
        for (int i = 0; i < NP; i++) begin
            fifo_empty[i] = (q[i].size() == 0);
            fifo_data[i*UW +: UW] = (q[i].size() == 0) ? 8'h00 : q[i][0];
        end
    endtask

    // One clock: sample on the falling edge, then apply FIFO pops just after the rising edge.
    task automatic tick();
        logic [NP-1:0] rd;
        @(negedge clk2);
        cyc++;
        rd = fifo_rd;
        if (link_valid && link_ready) begin
            rx.push_back(link_data);
            rx_cyc.push_back(cyc);
        end
        if (grant != 0 && last_grant == 0) begin
            grant_log.push_back(int'(grant));
            grant_cyc = cyc;
        end
        last_grant = grant;
        if (pkt_done) begin
            done_cnt++;
            last_done_cyc = cyc;
            last_crc_err  = crc_err;
        end
        if ((rd & ~grant) != 0 || $countones(rd) > 1) viol++;
        if (prev_stall && (link_valid !== 1'b1 || link_data !== prev_data)) viol++;
        prev_stall = link_valid && !link_ready;
        prev_data  = link_data;
        pops_total += $countones(rd);
        @(posedge clk2);
        #1;
        for (int i = 0; i < NP; i++) begin
            if (rd[i]) begin
                if (q[i].size() == 0) viol++;
                else void'(q[i].pop_front());
            end
        end
        refresh();
    endtask

    initial begin
        int d0, load_cyc, left, mism, g, p0;
        bit flushed;

        vecs[0] = '{1, 7,  '{0, 16, 3, 0, 1, 2, 1, 0, 0, 0, 0, 0, 0}, 2, 7, 0, 1'b0};
        vecs[1] = '{0, 4,  '{0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 1, 4, 0, 1'b0};
        vecs[2] = '{1, 11, '{1, 3, 7, 1, 2, 3, 4, 5, 6, 7, 0, 0, 0}, 2, 11, 0, 1'b0};
        vecs[3] = '{2, 9,  '{2, 254, 5, 0, 1, 2, 3, 4, 1, 0, 0, 0, 0}, 4, 9, 0, 1'b0};
        vecs[4] = '{2, 9,  '{2, 254, 5, 0, 1, 2, 3, 4, 0, 0, 0, 0, 0}, 4, 9, 0, 1'b1};
        vecs[5] = '{2, 13, '{2, 7, 9, 1, 2, 3, 4, 5, 6, 7, 8, 9, 9}, 4, 11, 2, 1'b1};

        tests = 0; fails = 0; viol = 0; cyc = 0; done_cnt = 0; pops_total = 0;
        last_grant = '0; prev_stall = 1'b0; prev_data = '0; grant_cyc = -1;
        last_done_cyc = 0; last_crc_err = 1'b0;
        link_ready = 1'b1;
        refresh();

        // Reset state
        repeat (3) @(negedge clk2);
        check("reset_grant", int'(grant), 0);
        check("reset_link_valid", int'(link_valid), 0);
        check("reset_link_data", int'(link_data), 0);
        check("reset_pkt_done", int'(pkt_done), 0);
        check("reset_crc_err", int'(crc_err), 0);
        check("reset_fifo_rd", int'(fifo_rd), 0);
        rst = 1'b1;
        @(posedge clk2);
        #1;

        // Packet table, one packet at a time with the link always ready
        for (int v = 0; v < 6; v++) begin
            rx.delete();
            rx_cyc.delete();
            d0 = done_cnt;
            grant_cyc = -1;
            for (int k = 0; k < vecs[v].n; k++) q[vecs[v].port].push_back(vecs[v].b[k]);
            refresh();
            load_cyc = cyc;
            flushed = 1'b0;
            left = -1;
            for (int c = 0; c < 100 && done_cnt == d0; c++) begin
                tick();
                if (!flushed && rx.size() == vecs[v].exp_fwd) begin
                    left = q[vecs[v].port].size();
                    q[vecs[v].port].delete();
                    refresh();
                    flushed = 1'b1;
                end
            end
            g = (grant_log.size() > 0) ? grant_log[grant_log.size()-1] : 0;
            mism = 0;
            for (int k = 0; k < rx.size() && k < vecs[v].exp_fwd; k++)
                if (rx[k] !== vecs[v].b[k]) mism++;
            check($sformatf("v%0d_pkt_done", v), done_cnt - d0, 1);
            check($sformatf("v%0d_grant", v), g, vecs[v].exp_grant);
            // Request is first visible the cycle after loading; grant follows one cycle later.
            check($sformatf("v%0d_grant_latency", v), grant_cyc - load_cyc, 2);
            check($sformatf("v%0d_byte_count", v), rx.size(), vecs[v].exp_fwd);
            check($sformatf("v%0d_byte_mismatches", v), mism, 0);
            check($sformatf("v%0d_byte_span", v),
                  (rx_cyc.size() > 0) ? rx_cyc[rx_cyc.size()-1] - rx_cyc[0] : -1, vecs[v].exp_fwd - 1);
            check($sformatf("v%0d_done_after_crc", v),
                  (rx_cyc.size() > 0) ? last_done_cyc - rx_cyc[rx_cyc.size()-1] : -1, 1);
            check($sformatf("v%0d_crc_err", v), int'(last_crc_err), int'(CRC_EN && vecs[v].crc_bad));
            check($sformatf("v%0d_leftover", v), left, vecs[v].exp_left);
            $display("[TB] vector %0d: port %0d grant %0d bytes %0d crc_err %0d", v, vecs[v].port, g,
                     rx.size(), last_crc_err);
            if (!flushed) begin
                q[vecs[v].port].delete();
                refresh();
            end
        end

        // All ports loaded with two packets each: strict rotation 0,1,2,0,1,2
        grant_log.delete();
        rx.delete();
        rx_cyc.delete();
        d0 = done_cnt;
        for (int i = 0; i < NP; i++)
            for (int pk = 0; pk < 2; pk++) begin
                q[i].push_back(8'(i)); q[i].push_back(8'd9);
                q[i].push_back(8'd0);  q[i].push_back(8'd0);
            end
        refresh();
        for (int c = 0; c < 300 && done_cnt - d0 < 6; c++) tick();
        check("rr_packets", done_cnt - d0, 6);
        for (int k = 0; k < 6; k++) check($sformatf("rr_grant_%0d", k), log_at(k), rr_exp[k]);
        check("rr_bytes", rx.size(), 24);
        $display("[TB] round-robin: %0d packets, %0d bytes", done_cnt - d0, rx.size());

        // Back-pressure for 5 cycles after four bytes have gone out
        rx.delete();
        rx_cyc.delete();
        d0 = done_cnt;
        for (int k = 0; k < 7; k++) q[0].push_back(stall_pkt[k]);
        refresh();
        for (int c = 0; c < 50 && rx.size() < 4; c++) tick();
        check("stall_prefix", rx.size(), 4);
        link_ready = 1'b0;
        p0 = pops_total;
        repeat (5) tick();
        check("stall_pops", pops_total - p0, 0);
        check("stall_link_valid", int'(link_valid), 1);
        check("stall_link_data", int'(link_data), 11);
        link_ready = 1'b1;
        for (int c = 0; c < 50 && done_cnt == d0; c++) tick();
        mism = 0;
        for (int k = 0; k < rx.size() && k < 7; k++) if (rx[k] !== stall_pkt[k]) mism++;
        check("stall_byte_count", rx.size(), 7);
        check("stall_byte_mismatches", mism, 0);
        $display("[TB] back-pressure: %0d bytes after 5-cycle stall", rx.size());

        // Asynchronous reset in the middle of a packet
        rx.delete();
        rx_cyc.delete();
        for (int k = 0; k < 8; k++) q[2].push_back(8'(k + 2));
        refresh();
        for (int c = 0; c < 50 && rx.size() < 2; c++) tick();
        check("midrst_started", int'(rx.size() >= 2), 1);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_grant", int'(grant), 0);
        check("midrst_link_valid", int'(link_valid), 0);
        check("midrst_fifo_rd", int'(fifo_rd), 0);
        check("midrst_link_data", int'(link_data), 0);
        for (int i = 0; i < NP; i++) q[i].delete();
        refresh();
        @(negedge clk2);
        rst = 1'b1;
        last_grant = '0;
        prev_stall = 1'b0;
        @(posedge clk2);
        #1;
        grant_log.delete();
        d0 = done_cnt;
        q[1].push_back(8'd1); q[1].push_back(8'd2); q[1].push_back(8'd0); q[1].push_back(8'd0);
        q[0].push_back(8'd0); q[0].push_back(8'd2); q[0].push_back(8'd0); q[0].push_back(8'd0);
        refresh();
        for (int c = 0; c < 100 && done_cnt - d0 < 2; c++) tick();
        check("postrst_packets", done_cnt - d0, 2);
        check("postrst_first_grant", log_at(0), 1);
        check("postrst_second_grant", log_at(1), 2);
        $display("[TB] mid-packet reset: grants after release %0d then %0d", log_at(0), log_at(1));

        check("protocol_violations", viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
